// File: rtl/chacha20_pio_pkg.sv
// chacha20_pio_pkg
// Shared constants for the ChaCha20 system input PIO with edge capture.
//   - Avalon register addresses (DATA, IRQMASK, EDGECAP; address 1 is reserved)
//   - Edge-type selectors for the EDGE_TYPE parameter
package chacha20_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/chacha20_pio_sync.sv
// chacha20_pio_sync
// WIDTH-wide input synchroniser followed by a one-cycle history flop and
// per-bit edge detection.
// Ports:
//   i_clk      system clock
//   i_reset    asynchronous active-high reset, clears every flop
//   i_in_port  asynchronous external input
//   o_sync     synchronised input (last stage of the chain)
//   o_edge     one-cycle pulse per bit when the selected edge is seen on o_sync
module chacha20_pio_sync
    import chacha20_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_in_port,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] r_chain [SYNC_STAGES];
    logic [WIDTH-1:0] r_sync_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_chain[i] <= '0;
            end
            r_sync_d <= '0;
        end else begin
            r_chain[0] <= i_in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_sync_d <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

    // Any unrecognised EDGE_TYPE value falls back to rising-edge detection.
    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign o_edge = ~o_sync & r_sync_d;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign o_edge = o_sync ^ r_sync_d;
        end else begin : g_rise
            assign o_edge = o_sync & ~r_sync_d;
        end
    endgenerate

endmodule

// File: rtl/chacha20_pio_in_edge.sv
// chacha20_pio_in_edge
// Avalon-MM input PIO for the ChaCha20 system bus: synchronised input data,
// per-bit edge capture (write-1-to-clear) and a maskable level interrupt.
// Register map: 0 DATA (RO), 1 reserved (reads 0), 2 IRQMASK (RW),
// 3 EDGECAP (W1C). Unused bits read 0.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   address      register select
//   chipselect   qualifies writes (write = chipselect & ~write_n)
//   write_n      active-low write strobe
//   writedata    write data, only the low WIDTH bits are meaningful
//   in_port      asynchronous external input
//   readdata     registered read data, one clock after address
//   irq          |(EDGECAP & IRQMASK)
module chacha20_pio_in_edge
    import chacha20_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;
    logic [31:0]      w_rd_mux;
    logic             w_wr;
    logic             w_unused_wdata;

    chacha20_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_in_port (in_port),
        .o_sync    (w_sync),
        .o_edge    (w_edge)
    );

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && (address == PIO_ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    // Bits of writedata above WIDTH are deliberately ignored.
    assign w_unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_wr && (address == PIO_ADDR_IRQMASK)) begin
            r_irqmask <= writedata[WIDTH-1:0];
        end
    end

    // The set term is OR'ed in after the clear so an edge arriving in the
    // same cycle as a W1C write to that bit is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            PIO_ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_sync;
            PIO_ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
            PIO_ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edgecap;
            default:          w_rd_mux = '0;
        endcase
    end

    // Read data is sampled every cycle; there is no read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: doc/chacha20_pio_in_edge.md
# chacha20_pio_in_edge

Parametrised Avalon-MM input PIO with input synchronisation, per-bit edge capture and a maskable interrupt. It replaces the fixed 8-bit, data-only input port on the ChaCha20 embedded-system bus. Nios II software can therefore poll the sampled input or take an interrupt on selected edges, for example a "character valid" strobe, instead of busy-waiting on the data register.

## Interface
- `WIDTH`, default 8: input port width, 1..32.
- `SYNC_STAGES`, default 2: synchroniser depth, 2..4.
- `EDGE_TYPE`, default 0: edge detected; 0 = rising, 1 = falling, 2 = any.
- `clk`  in  1: single system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `address`  in  2: Avalon register select.
- `chipselect`  in  1: qualifies writes.
- `write_n`  in  1: active-low write strobe.
- `writedata`  in  32: write data.
- `in_port`  in  WIDTH: asynchronous external input.
- `readdata`  out  32: registered read data.
- `irq`  out  1: level interrupt to the CPU.

## Operation
- Register map (all unused bits read 0; writes to them are ignored):
  - 0: DATA, RO. Synchronised `in_port` value.
  - 1: reserved. Reads 0; writes ignored.
  - 2: IRQMASK, RW, WIDTH bits.
  - 3: EDGECAP, W1C, WIDTH bits.
- Synchroniser: each `in_port` bit passes through a chain of `SYNC_STAGES` flops to give `sync`. One further flop holds `sync_d`.
- Edge detect per bit, combinational:
  - rising: `sync & ~sync_d`
  - falling: `~sync & sync_d`
  - any: `sync ^ sync_d`
- EDGECAP bit update, evaluated every cycle:
  - Set when an edge is detected.
  - Cleared by a write to address 3 with that `writedata` bit = 1.
  - Simultaneous set and clear on the same bit: set wins, so no edge is lost.
  - Writing 0 bits leaves those bits unchanged.
- A write happens when `chipselect`=1 and `write_n`=0. Writes to addresses 0 and 1 have no effect.
- `irq` = |(EDGECAP & IRQMASK), driven combinationally from those two registers only. It stays high until software clears the captured bits or masks them.
- `readdata` is registered every cycle from the address mux, independent of any read strobe, and is zero-extended to 32 bits.
- Reset drives `readdata`, IRQMASK, EDGECAP, all synchroniser flops and `sync_d` to 0, so `irq`=0.
- If `in_port` is high through reset, it is reported as a rising edge (EDGE_TYPE 0 or 2) `SYNC_STAGES`+1 clocks after reset deasserts. Software must clear EDGECAP after boot.
- Reset asserted mid-operation clears all state immediately. Pending edges are discarded.

## Timing
- Read latency is 1 clock: `readdata` reflects the `address` sampled at the previous edge. No wait states.
- `in_port` change stable before edge 1:
  - `sync` updates at edge `SYNC_STAGES`.
  - EDGECAP bit and `irq` assert after edge `SYNC_STAGES`+1.
  - A DATA read shows the new value on `readdata` after edge `SYNC_STAGES`+1, given address 0 was presented before it.
- IRQMASK and EDGECAP writes take effect at the write edge. `irq` responds in the same cycle the registers change.
- Input pulses shorter than one clock may be missed. This is by design; there is no pulse stretching.

## Structure
- Package `chacha20_pio_pkg` holds:
  - Address constants `PIO_ADDR_DATA`=0, `PIO_ADDR_IRQMASK`=2, `PIO_ADDR_EDGECAP`=3.
  - Edge-type constants `EDGE_RISE`=0, `EDGE_FALL`=1, `EDGE_ANY`=2.
- Sub-module `chacha20_pio_sync` contains the WIDTH-wide synchroniser chain, the `sync_d` flop and the edge-detect logic. Its outputs are `sync[WIDTH-1:0]` and `edge[WIDTH-1:0]`.
- The top level contains the register file, write decode, read mux and `irq` logic.

## Test plan
All scenarios use WIDTH=8, SYNC_STAGES=2.
- Reset with `in_port`=0x00 → `readdata`=0 and `irq`=0. Then drive `in_port`=0xA5 with address 0 held → `readdata`=0x000000A5 exactly 3 clocks later, and EDGECAP=0xA5 (EDGE_TYPE 0).
- IRQMASK=0x01, `in_port` bit0 0→1 → `irq`=1 at edge 3. Write 0x01 to address 3 → `irq`=0 the next cycle, and a read of EDGECAP returns 0.
- EDGE_TYPE=1: `in_port` 0xFF→0x0F → EDGECAP=0xF0. EDGE_TYPE=2: 0x0F→0x3C → EDGECAP=0x33.
- New edge on bit2 in the same cycle as a W1C write of 0x04 → EDGECAP bit2 remains 1. A W1C write of 0x00 → no change.
- `in_port`=0x80 held through reset → EDGECAP=0x80 3 clocks after reset falls. Assert `reset` mid-operation → EDGECAP, IRQMASK, `readdata` and `irq` are 0 immediately (asynchronously).
- Writes to addresses 0 and 1 → no state change. Address 1 reads 0. IRQMASK write of 0xFFFFFFFF reads back 0x000000FF.
